// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Contents: FSM state enum, iteration counts, datapath widths, result payload.
package multdiv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PP_W      = XLEN + 2;       // Booth addend width (holds +-2M)
  localparam int unsigned WORK_W    = 2 * XLEN + 2;   // {acc[32:0], low[31:0], guard}
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned MUL_ITERS = 16;
  localparam int unsigned DIV_ITERS = 32;

  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] value;
    logic            exc;
  } mdu_result_t;

endpackage

// File: rtl/booth4_select.sv
// Radix-4 modified Booth recoder: maps a 3-bit multiplier window onto the
// {0, +M, +2M, -M, -2M} partial-product addend, sign-extended to PP_W bits.
// Ports: win_i (window {b[i+1], b[i], b[i-1]}), mcand_i (signed multiplicand),
//        pp_c (combinational addend).
module booth4_select
  import multdiv_pkg::*;
(
  input  logic [2:0]      win_i,
  input  logic [XLEN-1:0] mcand_i,
  output logic [PP_W-1:0] pp_c
);

  logic [PP_W-1:0] m1_c;
  logic [PP_W-1:0] m2_c;

  always_comb begin
    m1_c = {{2{mcand_i[XLEN-1]}}, mcand_i};
    m2_c = {mcand_i[XLEN-1], mcand_i, 1'b0};
    pp_c = '0;
    case (win_i)
      3'b001, 3'b010: pp_c = m1_c;
      3'b011:         pp_c = m2_c;
      3'b100:         pp_c = ~m2_c + PP_W'(1);
      3'b101, 3'b110: pp_c = ~m1_c + PP_W'(1);
      default:        pp_c = '0;
    endcase
  end

endmodule

// File: rtl/seq_multdiv_unit.sv
// Multi-cycle signed 32-bit multiplier/divider for the execute stage.
// Multiply: radix-4 Booth, 16 iterations; divide: restoring, 32 iterations.
// Build option: define MULTDIV_DIV_EN to build the divider; without it a
//   divide start is rejected (result 0, exception 1) two edges later.
// Ports: clock, reset (async active-low), data_operandA/B (signed operands),
//   ctrl_MULT/ctrl_DIV (start pulses, MULT has priority), data_result,
//   data_exception (registered result/overflow), data_resultRDY (1-cycle done).
module seq_multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORK_W-1:0]   work_q, work_d;   // mul: {acc, multiplier, guard}; div: {rem, quotient, 0}
  logic [XLEN-1:0]     mcand_q, mcand_d; // mul: multiplicand; div: divisor magnitude
  mdu_result_t         res_q, res_d;
  logic                rdy_q, rdy_d;

  logic                start_mul_c;
  logic                start_div_c;

  // Booth multiply step datapath
  logic [PP_W-1:0]     pp_c;
  logic [PP_W-1:0]     mul_sum_c;
  logic [WORK_W-1:0]   mul_next_c;
  logic [2*XLEN-1:0]   product_c;
  logic [XLEN:0]       prod_hi_c;
  logic                mul_ovf_c;

  booth4_select u_booth4_select (
    .win_i   (work_q[2:0]),
    .mcand_i (mcand_q),
    .pp_c    (pp_c)
  );

  // Add addend to sign-extended accumulator, then arithmetic shift right by 2.
  always_comb begin
    mul_sum_c  = {work_q[WORK_W-1], work_q[WORK_W-1:XLEN+1]} + pp_c;
    mul_next_c = {mul_sum_c[PP_W-1], mul_sum_c, work_q[XLEN:2]};
    product_c  = mul_next_c[2*XLEN:1];
    prod_hi_c  = product_c[2*XLEN-1:XLEN-1];
    mul_ovf_c  = ~((&prod_hi_c) | ~(|prod_hi_c));
  end

`ifdef MULTDIV_DIV_EN
  logic                neg_q, neg_d;       // quotient needs negation
  logic                spec_q, spec_d;     // special case resolved at start
  logic                spec_ovf_q, spec_ovf_d;

  logic [XLEN-1:0]     a_mag_c;
  logic [XLEN-1:0]     b_mag_c;
  logic [XLEN:0]       rem_sh_c;
  logic [XLEN:0]       trial_c;
  logic                qbit_c;
  logic [WORK_W-1:0]   div_next_c;
  logic [XLEN-1:0]     quo_c;
  logic [XLEN-1:0]     div_res_c;

  // Restoring division step: shift in next dividend bit, trial subtract, restore on borrow.
  always_comb begin
    a_mag_c    = data_operandA[XLEN-1] ? (~data_operandA + XLEN'(1)) : data_operandA;
    b_mag_c    = data_operandB[XLEN-1] ? (~data_operandB + XLEN'(1)) : data_operandB;
    rem_sh_c   = {work_q[WORK_W-2:XLEN+1], work_q[XLEN]};
    trial_c    = rem_sh_c - {1'b0, mcand_q};
    qbit_c     = ~trial_c[XLEN];
    div_next_c = {(qbit_c ? trial_c : rem_sh_c), work_q[XLEN-1:1], qbit_c, 1'b0};
    quo_c      = div_next_c[XLEN:1];
    div_res_c  = neg_q ? (~quo_c + XLEN'(1)) : quo_c;
  end
`endif

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      mcand_q    <= '0;
      res_q      <= '0;
      rdy_q      <= 1'b0;
`ifdef MULTDIV_DIV_EN
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_ovf_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      mcand_q    <= mcand_d;
      res_q      <= res_d;
      rdy_q      <= rdy_d;
`ifdef MULTDIV_DIV_EN
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_ovf_q <= spec_ovf_d;
`endif
    end
  end

  // Next-state, iteration and start handling
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    mcand_d    = mcand_q;
    res_d      = res_q;
    rdy_d      = 1'b0;
`ifdef MULTDIV_DIV_EN
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_ovf_d = spec_ovf_q;
`endif

    start_mul_c = ctrl_MULT;
    start_div_c = ctrl_DIV & ~ctrl_MULT;

    case (state_q)
      IDLE: ;
      MUL: begin
        work_d = mul_next_c;
        if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
          state_d   = DONE;
          res_d.value = product_c[XLEN-1:0];
          res_d.exc   = mul_ovf_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV: begin
`ifdef MULTDIV_DIV_EN
        if (spec_q) begin
          state_d     = DONE;
          res_d.value = spec_ovf_q ? INT_MIN : '0;
          res_d.exc   = 1'b1;
        end else begin
          work_d = div_next_c;
          if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            state_d     = DONE;
            res_d.value = div_res_c;
            res_d.exc   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`else
        // No divider: reject the request one cycle after it was taken.
        state_d     = DONE;
        res_d.value = '0;
        res_d.exc   = 1'b1;
`endif
      end
      DONE: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A new start overrides whatever is in flight, including a pending RDY.
    if (start_mul_c) begin
      state_d = MUL;
      cnt_d   = '0;
      work_d  = {{(XLEN+1){1'b0}}, data_operandB, 1'b0};
      mcand_d = data_operandA;
      rdy_d   = 1'b0;
    end else if (start_div_c) begin
      state_d = DIV;
      cnt_d   = '0;
      rdy_d   = 1'b0;
`ifdef MULTDIV_DIV_EN
      work_d     = {{(XLEN+1){1'b0}}, a_mag_c, 1'b0};
      mcand_d    = b_mag_c;
      neg_d      = data_operandA[XLEN-1] ^ data_operandB[XLEN-1];
      spec_ovf_d = (data_operandB != '0);
      spec_d     = (data_operandB == '0) ||
                   ((data_operandA == INT_MIN) && (data_operandB == '1));
`endif
    end
  end

  assign data_result    = res_q.value;
  assign data_exception = res_q.exc;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_seq_multdiv_unit.sv
// Directed self-checking bench for seq_multdiv_unit (both MULTDIV_DIV_EN builds).
module tb_seq_multdiv_unit;

`ifdef MULTDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_checks = 0;
  int n_pass   = 0;

  seq_multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse a start at edge 0, then wait for RDY; lat is the edge number or -1.
  task automatic run_op(input logic mul, input logic div, input logic [31:0] a,
                        input logic [31:0] b, input int budget, output int lat,
                        output logic [31:0] res, output logic exc);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    lat = -1;
    res = 32'hxxxx_xxxx;
    exc = 1'bx;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        lat = n;
        res = data_result;
        exc = data_exception;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (data_result !== 32'h0) $display("FAIL reset_result got %h exp %h", data_result, 32'h0);
    else n_pass++;
    n_checks++;
    if (data_exception !== 1'b0) $display("FAIL reset_exc got %b exp 0", data_exception);
    else n_pass++;
    n_checks++;
    if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy got %b exp 0", data_resultRDY);
    else n_pass++;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (data_resultRDY !== 1'b0) $display("FAIL idle_rdy got %b exp 0", data_resultRDY);
    else n_pass++;
  endtask

  task automatic test_mult();
    int lat; logic [31:0] res; logic exc;
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 40, lat, res, exc);
    n_checks++;
    if (lat !== 17) $display("FAIL mul7x-6_latency got %0d exp 17", lat); else n_pass++;
    n_checks++;
    if (res !== 32'hFFFF_FFD6) $display("FAIL mul7x-6_result got %h exp ffffffd6", res); else n_pass++;
    n_checks++;
    if (exc !== 1'b0) $display("FAIL mul7x-6_exc got %b exp 0", exc); else n_pass++;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (data_resultRDY !== 1'b0) $display("FAIL mul_rdy_single got %b exp 0", data_resultRDY); else n_pass++;
    n_checks++;
    if (data_result !== 32'hFFFF_FFD6) $display("FAIL mul_result_hold got %h exp ffffffd6", data_result); else n_pass++;

    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 40, lat, res, exc);
    n_checks++;
    if (res !== 32'h0 || exc !== 1'b1)
      $display("FAIL mul_ovf got %h/%b exp 00000000/1", res, exc); else n_pass++;

    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 40, lat, res, exc);
    n_checks++;
    if (res !== 32'h7FFF_FFFF || exc !== 1'b0)
      $display("FAIL mul_max got %h/%b exp 7fffffff/0", res, exc); else n_pass++;

    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 40, lat, res, exc);
    n_checks++;
    if (res !== 32'h8000_0000 || exc !== 1'b1)
      $display("FAIL mul_min_neg1 got %h/%b exp 80000000/1", res, exc); else n_pass++;
  endtask

  task automatic test_div();
    int lat; logic [31:0] res; logic exc;
    int exp_lat; logic [31:0] exp_res; logic exp_exc;
    exp_lat = DIV_ON ? 33 : 2;
    exp_res = DIV_ON ? 32'hFFFF_FFF2 : 32'h0;
    exp_exc = DIV_ON ? 1'b0 : 1'b1;
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 60, lat, res, exc);
    n_checks++;
    if (lat !== exp_lat) $display("FAIL div-100/7_latency got %0d exp %0d", lat, exp_lat); else n_pass++;
    n_checks++;
    if (res !== exp_res || exc !== exp_exc)
      $display("FAIL div-100/7 got %h/%b exp %h/%b", res, exc, exp_res, exp_exc); else n_pass++;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (data_resultRDY !== 1'b0) $display("FAIL div_rdy_single got %b exp 0", data_resultRDY); else n_pass++;

    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 60, lat, res, exc);
    n_checks++;
    if (res !== exp_res || exc !== exp_exc)
      $display("FAIL div100/-7 got %h/%b exp %h/%b", res, exc, exp_res, exp_exc); else n_pass++;

    exp_res = DIV_ON ? 32'd142 : 32'h0;
    run_op(1'b0, 1'b1, 32'd1000, 32'd7, 60, lat, res, exc);
    n_checks++;
    if (res !== exp_res || exc !== exp_exc)
      $display("FAIL div1000/7 got %h/%b exp %h/%b", res, exc, exp_res, exp_exc); else n_pass++;
  endtask

  task automatic test_div_special();
    int lat; logic [31:0] res; logic exc;
    logic [31:0] exp_res;
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 60, lat, res, exc);
    n_checks++;
    if (lat !== 2) $display("FAIL div_by_zero_latency got %0d exp 2", lat); else n_pass++;
    n_checks++;
    if (res !== 32'h0 || exc !== 1'b1)
      $display("FAIL div_by_zero got %h/%b exp 00000000/1", res, exc); else n_pass++;

    exp_res = DIV_ON ? 32'h8000_0000 : 32'h0;
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 60, lat, res, exc);
    n_checks++;
    if (lat !== 2) $display("FAIL div_ovf_latency got %0d exp 2", lat); else n_pass++;
    n_checks++;
    if (res !== exp_res || exc !== 1'b1)
      $display("FAIL div_ovf got %h/%b exp %h/1", res, exc, exp_res); else n_pass++;
  endtask

  task automatic test_abort();
    int lat; logic [31:0] res; logic exc;
    int exp_lat; logic [31:0] exp_res; logic exp_exc;
    logic saw;
    exp_lat = DIV_ON ? 38 : 7;
    exp_res = DIV_ON ? 32'd4 : 32'd0;
    exp_exc = DIV_ON ? 1'b0 : 1'b1;
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    saw = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY !== 1'b0) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) $display("FAIL abort_early_rdy got %b exp 0", saw); else n_pass++;
    // run_op starts the DIV at edge 5 relative to the MULT start.
    run_op(1'b0, 1'b1, 32'd20, 32'd5, 60, lat, res, exc);
    if (lat > 0) lat = lat + 5;
    n_checks++;
    if (lat !== exp_lat) $display("FAIL abort_latency got %0d exp %0d", lat, exp_lat); else n_pass++;
    n_checks++;
    if (res !== exp_res || exc !== exp_exc)
      $display("FAIL abort_result got %h/%b exp %h/%b", res, exc, exp_res, exp_exc); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int lat; logic [31:0] res; logic exc;
    run_op(1'b1, 1'b1, 32'd2, 32'd3, 60, lat, res, exc);
    n_checks++;
    if (lat !== 17) $display("FAIL both_latency got %0d exp 17", lat); else n_pass++;
    n_checks++;
    if (res !== 32'd6 || exc !== 1'b0)
      $display("FAIL both_result got %h/%b exp 00000006/0", res, exc); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int lat; logic [31:0] res; logic exc;
    logic saw;
    // Leave nonzero outputs behind so the reset clear is observable.
    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0003, 40, lat, res, exc);
    n_checks++;
    if (res !== 32'h0003_0000 || exc !== 1'b1)
      $display("FAIL pre_reset_mul got %h/%b exp 00030000/1", res, exc); else n_pass++;
    @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_MULT = !DIV_ON;
    ctrl_DIV  = DIV_ON;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    saw = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY !== 1'b0) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) $display("FAIL midop_early_rdy got %b exp 0", saw); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0)
      $display("FAIL midop_reset_outputs got %h/%b/%b exp 00000000/0/0",
               data_result, data_exception, data_resultRDY);
    else n_pass++;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY !== 1'b0) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) $display("FAIL post_reset_rdy got %b exp 0", saw); else n_pass++;
    run_op(1'b1, 1'b0, 32'd2, 32'd2, 40, lat, res, exc);
    n_checks++;
    if (lat !== 17 || res !== 32'd4 || exc !== 1'b0)
      $display("FAIL post_reset_mul got lat %0d %h/%b exp lat 17 00000004/0", lat, res, exc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_abort();
    test_simultaneous();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
